voltammetry_wave_engine: RTL and testbench

VOLTAMMETRY_WAVE_ENGINE -- requirements
Module: voltammetry_wave_engine

---
 rtl/voltammetry_wave_engine.sv | 153 +++++++++++++++
 tb/tb_voltammetry_wave_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/voltammetry_wave_engine.sv
// voltammetry_wave_engine
// Steps an electrode potential through a programmed waveform (square-wave,
// staircase, cyclic or hold). Near the end of each step it streams a
// {potential, adc_ref} frame to a byte-wide DAC and then pulses the latch.
//
// Ports
//   clk, rst              clock, async active-high reset
//   cfg_we/addr/wdata     register writes (ignored while busy)
//                         0 adc_ref 1 e_init 2 e_step 3 e_amp 4 period
//                         5 step_max 6 vertex 7 mode
//   start, abort          single-cycle run request / cancel (abort wins)
//   dac_data, dac_data_en frame byte stream, MSB byte first
//   dac_set               DAC latch pulse at t = period-2
//   shield                electrode shield drive, 8'hFF while running
//   busy, done            run active / one-cycle completion pulse
//   cfg_err               sticky: last start had a too-short period
//   step_count            current step index
module voltammetry_wave_engine #(
  parameter int DAC_W  = 12,
  parameter int TIME_W = 32,
  parameter int STEP_W = 16,
  parameter int LEAD   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              start,
  input  logic              abort,
  output logic [7:0]        dac_data,
  output logic              dac_data_en,
  output logic              dac_set,
  output logic [7:0]        shield,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [STEP_W-1:0] step_count
);
  localparam int FRAME_BYTES = (2*DAC_W + 7) / 8;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  // Frame must fit before dac_set, with a spare cycle for the latch.
  localparam int MIN_PERIOD  = LEAD + FRAME_BYTES + 2;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_n;

  logic [DAC_W-1:0]  adc_ref, e_init, e_step, e_amp;
  logic [TIME_W-1:0] period;
  logic [STEP_W-1:0] step_max, vertex;
  logic [1:0]        mode;

  logic [TIME_W-1:0] t;
  logic [DAC_W-1:0]  v;

  logic start_req, period_ok, step_end, last_step;
  assign start_req = start && !abort;
  assign period_ok = {1'b0, period} >= (TIME_W+1)'(MIN_PERIOD);
  assign step_end  = (t == period - TIME_W'(1));
  assign last_step = (step_count == step_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_req && period_ok) state_n = RUN;
      RUN:     if (abort) state_n = IDLE;
               else if (step_end && last_step) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from registered state so reset and abort clear them
  // without waiting on any datapath register.
  assign busy   = (state == RUN);
  assign done   = (state == FINISH);
  assign shield = {8{busy}};

  logic [TIME_W-1:0]  frame_start, byte_idx;
  logic [FRAME_W-1:0] frame, frame_sh;
  assign frame_start = period - TIME_W'(LEAD);
  assign byte_idx    = t - frame_start;
  assign frame       = FRAME_W'({v, adc_ref}) << (FRAME_W - 2*DAC_W);
  assign frame_sh    = frame << {byte_idx, 3'b000};
  assign dac_data_en = busy && (t >= frame_start) && (byte_idx < TIME_W'(FRAME_BYTES));
  assign dac_data    = dac_data_en ? frame_sh[FRAME_W-1 -: 8] : 8'h00;
  assign dac_set     = busy && (t == period - TIME_W'(2));

  // Two guard bits: bit DAC_W+1 flags underflow, bit DAC_W flags overflow.
  logic [DAC_W+1:0] v_sum;
  logic [DAC_W-1:0] v_sat;
  always_comb begin
    v_sum = {2'b00, v};
    case (mode)
      2'd0: v_sum = step_count[0] ? {2'b00, v} + {2'b00, e_step}
                                  : {2'b00, v} - {2'b00, e_amp};
      2'd1: v_sum = {2'b00, v} + {2'b00, e_step};
      2'd2: v_sum = (step_count <= vertex) ? {2'b00, v} + {2'b00, e_step}
                                           : {2'b00, v} - {2'b00, e_step};
      default: v_sum = {2'b00, v};
    endcase
    if (v_sum[DAC_W+1])  v_sat = '0;
    else if (v_sum[DAC_W]) v_sat = '1;
    else                 v_sat = v_sum[DAC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_ref <= '0; e_init <= '0; e_step <= '0; e_amp <= '0;
      period <= '0; step_max <= '0; vertex <= '0; mode <= '0;
      t <= '0; v <= '0; step_count <= '0; cfg_err <= 1'b0;
    end else begin
      if (cfg_we && !busy) begin
        case (cfg_addr)
          3'd0: adc_ref  <= cfg_wdata[DAC_W-1:0];
          3'd1: e_init   <= cfg_wdata[DAC_W-1:0];
          3'd2: e_step   <= cfg_wdata[DAC_W-1:0];
          3'd3: e_amp    <= cfg_wdata[DAC_W-1:0];
          3'd4: period   <= cfg_wdata[TIME_W-1:0];
          3'd5: step_max <= cfg_wdata[STEP_W-1:0];
          3'd6: vertex   <= cfg_wdata[STEP_W-1:0];
          3'd7: mode     <= cfg_wdata[1:0];
        endcase
      end
      case (state)
        IDLE: if (start_req) begin
          if (period_ok) begin
            t <= '0; step_count <= '0; v <= e_init; cfg_err <= 1'b0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        RUN: if (!abort) begin
          if (step_end) begin
            t <= '0;
            // Final index is held through FINISH and IDLE.
            if (!last_step) step_count <= step_count + STEP_W'(1);
          end else begin
            t <= t + TIME_W'(1);
          end
          // New step's potential lands at t=0, visible from t=1.
          if (t == '0 && step_count != '0) v <= v_sat;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voltammetry_wave_engine.sv
// Bench for voltammetry_wave_engine: directed and random runs, each checked
// cycle by cycle against a step/time model built from the waveform rules.
module tb_voltammetry_wave_engine;
  localparam int LEAD = 1000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_we = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [7:0]  dac_data, shield;
  logic        dac_data_en, dac_set, busy, done, cfg_err;
  logic [15:0] step_count;

  int total = 0, bad = 0;
  int m_mode, m_einit, m_estep, m_eamp, m_aref, m_per, m_smax, m_vtx;

  voltammetry_wave_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort), .dac_data(dac_data), .dac_data_en(dac_data_en),
    .dac_set(dac_set), .shield(shield), .busy(busy), .done(done), .cfg_err(cfg_err),
    .step_count(step_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {busy, shield, dac_data_en, dac_data, dac_set, done, step_count};
  endfunction

  task automatic wr(input int a, input int d);
    cfg_addr = 3'(a); cfg_wdata = 32'(d); cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int mode, input int einit, input int estep, input int eamp,
                         input int aref, input int per, input int smax, input int vtx);
    m_mode = mode; m_einit = einit; m_estep = estep; m_eamp = eamp;
    m_aref = aref; m_per = per; m_smax = smax; m_vtx = vtx;
    wr(0, aref); wr(1, einit); wr(2, estep); wr(3, eamp);
    wr(4, per); wr(5, smax); wr(6, vtx); wr(7, mode);
  endtask

  // Issues start and follows the whole run; abort_at >= 0 cancels the run
  // at that cycle offset from run entry.
  task automatic run(input string tag, input int abort_at);
    int vq[$];
    int vv, n, t, fs, frm, byt, b0, tot_c;
    bit en_b, set_b, failed, dseen;
    logic [35:0] e;
    vv = m_einit;
    vq.push_back(vv);
    for (int k = 1; k <= m_smax; k++) begin
      case (m_mode)
        0: vv = (k % 2 == 1) ? vv + m_estep : vv - m_eamp;
        1: vv = vv + m_estep;
        2: vv = (k <= m_vtx) ? vv + m_estep : vv - m_estep;
        default: ;
      endcase
      if (vv < 0) vv = 0;
      if (vv > 4095) vv = 4095;
      vq.push_back(vv);
    end
    tot_c = (m_smax + 1) * m_per;
    failed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_cfg_err"}, cfg_err, 0);
    for (int c = 0; c <= tot_c + 1 && !failed; c++) begin
      if (c < tot_c) begin
        n = c / m_per; t = c % m_per; fs = m_per - LEAD;
        en_b = (t >= fs) && (t < fs + 3);
        frm = (vq[n] << 12) | m_aref;
        byt = en_b ? (frm >> (8 * (2 - (t - fs)))) & 255 : 0;
        set_b = (t == m_per - 2);
        e = {1'b1, 8'hFF, en_b, 8'(byt), set_b, 1'b0, 16'(n)};
      end else begin
        e = {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, (c == tot_c), 16'(m_smax)};
      end
      b0 = bad;
      chk(tag, outs(), e);
      if (bad != b0) failed = 1'b1;
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({tag, "_abort"}, outs() >> 16, 0);
        dseen = 1'b0;
        repeat (5) begin @(negedge clk); dseen |= done; end
        chk({tag, "_no_done"}, dseen, 0);
        failed = 1'b1;
      end else begin
        // Writes while busy must not touch e_init / period.
        if (c == 5) begin cfg_addr = 3'd1; cfg_wdata = 32'h5A5; cfg_we = 1'b1; end
        if (c == 6) begin cfg_addr = 3'd4; cfg_wdata = 32'd7; end
        if (c == 7) cfg_we = 1'b0;
        @(negedge clk);
      end
    end
    cfg_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_err", cfg_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Period 1002 and the boundary 1004 are too short; 1005 is the minimum.
    cfg_all(1, 16, 1, 0, 0, 1002, 0, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("short_1002", {cfg_err, busy}, 2'b10);
    wr(4, 1004);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("short_1004", {cfg_err, busy}, 2'b10);
    cfg_all(1, 16, 1, 0, 0, 1005, 1, 0);
    run("min_period", -1);

    cfg_all(0, 'h800, 'h040, 'h020, 'hABC, 2000, 3, 0);
    run("swv", -1);
    cfg_all(2, 'h100, 'h100, 0, 'h123, 2000, 4, 2);
    run("cyclic", -1);
    cfg_all(1, 'hFF0, 'h020, 0, 'h456, 2000, 2, 0);
    run("stair_sat", -1);
    run("busy_wr_ignored", -1);
    cfg_all(0, 'h010, 'h004, 'h100, 'h0F0, 1005, 2, 0);
    run("swv_floor", -1);

    cfg_all(1, 'h300, 'h010, 0, 'h777, 2000, 3, 0);
    run("abort", 2000 + 1001);
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    for (int r = 0; r < 4; r++) begin
      cfg_all(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 4095)), int'($urandom_range(1005, 1200)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      run($sformatf("rand%0d", r), -1);
    end

    // Reset mid-run: immediate clear, no done, config back to zero.
    cfg_all(1, 'h100, 'h010, 0, 'h321, 2000, 3, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (1500) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_outs", outs(), 0);
    chk("rst_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit dseen;
      dseen = 1'b0;
      repeat (4) begin @(negedge clk); dseen |= done | busy; end
      chk("rst_no_done", dseen, 0);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("rst_cfg_cleared", {cfg_err, busy}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
